rob_recovery_ctrl: RTL and testbench

- Sequences reorder-buffer recovery after a branch mispredict or exception, and drives the 2-bit rob_state consumed by the pipeline stall/flush logic.
- Squashes ROB entries younger than the flush point, youngest first (ROLLBACK). Then replays the surviving entries from head so the rename map can be rebuilt (WALK).
- Sits beside the ROB. Its rob_state output is the sole source of the pipeline's rollback/walk stalls.

---
 rtl/rob_recovery_ctrl_if.sv | 52 +++++
 rtl/rob_recovery_ctrl.sv | 160 ++++++++++++++++
 tb/tb_rob_recovery_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_recovery_ctrl_if.sv
// rtl/rob_recovery_ctrl_if.sv - flush request / ROB status / recovery output bundle
//
// Groups every rob_recovery_ctrl signal except clk and reset_n.
//   master : the ROB/branch side. It drives flush_req, flush_idx, flush_incl,
//            rob_head and rob_count, and it observes the recovery outputs.
//   slave  : rob_recovery_ctrl. It observes the flush/ROB inputs and drives
//            rob_state, flush_valid, rb_valid/rb_base, walk_valid/walk_base,
//            recover_done, busy and flush_overrun.
// With RECOVERY_STATS_EN defined, the slave also drives stat_flushes and
// stat_cycles.
interface rob_recovery_ctrl_if #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 2,
  parameter int PTR_W = $clog2(DEPTH)
);
  logic             flush_req;
  logic [PTR_W-1:0] flush_idx;
  logic             flush_incl;
  logic [PTR_W-1:0] rob_head;
  logic [PTR_W:0]   rob_count;
  logic [1:0]       rob_state;
  logic             flush_valid;
  logic [WIDTH-1:0] rb_valid;
  logic [PTR_W-1:0] rb_base;
  logic [WIDTH-1:0] walk_valid;
  logic [PTR_W-1:0] walk_base;
  logic             recover_done;
  logic             busy;
  logic             flush_overrun;
`ifdef RECOVERY_STATS_EN
  logic [15:0]      stat_flushes;
  logic [31:0]      stat_cycles;
`endif

  modport master (
    output flush_req, flush_idx, flush_incl, rob_head, rob_count,
    input  rob_state, flush_valid, rb_valid, rb_base, walk_valid, walk_base,
           recover_done, busy, flush_overrun
`ifdef RECOVERY_STATS_EN
    , input stat_flushes, stat_cycles
`endif
  );

  modport slave (
    input  flush_req, flush_idx, flush_incl, rob_head, rob_count,
    output rob_state, flush_valid, rb_valid, rb_base, walk_valid, walk_base,
           recover_done, busy, flush_overrun
`ifdef RECOVERY_STATS_EN
    , output stat_flushes, stat_cycles
`endif
  );
endinterface

// File: rtl/rob_recovery_ctrl.sv
// rtl/rob_recovery_ctrl.sv - ROB rollback/walk recovery sequencer
//
// The sequencer first squashes the entries that are younger than the flush
// point, youngest first (ROLLBACK). It then replays the surviving entries
// from the head so that the rename map can be rebuilt (WALK).
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : flush request and ROB head/count in; rob_state, lane masks
//                  and bases, recover_done, busy, flush_overrun out
// Optional: RECOVERY_STATS_EN adds the saturating counters stat_flushes and
// stat_cycles.
// All outputs decode from registers only.
module rob_recovery_ctrl #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  rob_recovery_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ROB_IDLE     = 2'd0,
    ROB_ROLLBACK = 2'd1,
    ROB_WALK     = 2'd2
  } state_t;

  localparam logic [PTR_W:0] LANES = (PTR_W+1)'(WIDTH);

  state_t           state_q, state_d;
  logic [PTR_W-1:0] rb_ptr_q, rb_ptr_d, wk_ptr_q, wk_ptr_d;
  logic [PTR_W:0]   rb_rem_q, rb_rem_d, wk_rem_q, wk_rem_d;
  logic             first_q, first_d;
  logic             overrun_q, overrun_d;

  logic [PTR_W:0]   rb_n, wk_n;
  logic             rb_last, wk_last;
  logic [PTR_W-1:0] target, youngest, surv_mod;
  logic [PTR_W:0]   surv;
  logic [WIDTH-1:0] rb_valid_w, walk_valid_w;

  assign rb_n    = (rb_rem_q > LANES) ? LANES : rb_rem_q;
  assign wk_n    = (wk_rem_q > LANES) ? LANES : wk_rem_q;
  assign rb_last = (rb_rem_q <= LANES);
  assign wk_last = (wk_rem_q <= LANES);

  // Survivor count. The mispredict target wraps onto the head when the
  // offending entry is the youngest. This happens in a full ROB as well,
  // because the tail equals the head. The count therefore comes from
  // rob_count, not from a pointer difference.
  assign target   = bus.flush_idx + PTR_W'(!bus.flush_incl);
  assign youngest = bus.rob_head + bus.rob_count[PTR_W-1:0] - PTR_W'(1);
  assign surv_mod = target - bus.rob_head;
  assign surv     = (!bus.flush_incl && (bus.flush_idx == youngest)) ?
                    bus.rob_count : {1'b0, surv_mod};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ROB_IDLE;
      rb_ptr_q  <= '0;
      rb_rem_q  <= '0;
      wk_ptr_q  <= '0;
      wk_rem_q  <= '0;
      first_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rb_ptr_q  <= rb_ptr_d;
      rb_rem_q  <= rb_rem_d;
      wk_ptr_q  <= wk_ptr_d;
      wk_rem_q  <= wk_rem_d;
      first_q   <= first_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rb_ptr_d  = rb_ptr_q;
    rb_rem_d  = rb_rem_q;
    wk_ptr_d  = wk_ptr_q;
    wk_rem_d  = wk_rem_q;
    first_d   = first_q;
    // Any request while busy is dropped, including one in the
    // recover_done cycle.
    overrun_d = overrun_q | (bus.flush_req && (state_q != ROB_IDLE));
    case (state_q)
      ROB_IDLE: begin
        if (bus.flush_req) begin
          state_d  = ROB_ROLLBACK;
          rb_ptr_d = youngest;
          rb_rem_d = bus.rob_count - surv;
          wk_ptr_d = bus.rob_head;
          wk_rem_d = surv;
          first_d  = 1'b1;
        end
      end
      ROB_ROLLBACK: begin
        first_d  = 1'b0;
        rb_ptr_d = rb_ptr_q - PTR_W'(rb_n);
        rb_rem_d = rb_rem_q - rb_n;
        if (rb_last) begin
          state_d = (wk_rem_q != '0) ? ROB_WALK : ROB_IDLE;
        end
      end
      ROB_WALK: begin
        wk_ptr_d = wk_ptr_q + PTR_W'(wk_n);
        wk_rem_d = wk_rem_q - wk_n;
        if (wk_last) begin
          state_d = ROB_IDLE;
        end
      end
      default: state_d = ROB_IDLE;
    endcase
  end

  always_comb begin
    rb_valid_w   = '0;
    walk_valid_w = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rb_valid_w[i]   = (state_q == ROB_ROLLBACK) && ((PTR_W+1)'(i) < rb_n);
      walk_valid_w[i] = (state_q == ROB_WALK) && ((PTR_W+1)'(i) < wk_n);
    end
  end

  assign bus.rob_state     = state_q;
  assign bus.busy          = (state_q != ROB_IDLE);
  assign bus.flush_valid   = (state_q == ROB_ROLLBACK) && first_q;
  assign bus.rb_valid      = rb_valid_w;
  assign bus.rb_base       = (state_q == ROB_ROLLBACK) ? rb_ptr_q : '0;
  assign bus.walk_valid    = walk_valid_w;
  assign bus.walk_base     = (state_q == ROB_WALK) ? wk_ptr_q : '0;
  assign bus.recover_done  = ((state_q == ROB_ROLLBACK) && rb_last && (wk_rem_q == '0)) ||
                             ((state_q == ROB_WALK) && wk_last);
  assign bus.flush_overrun = overrun_q;

`ifdef RECOVERY_STATS_EN
  logic [15:0] stat_flushes_q;
  logic [31:0] stat_cycles_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_flushes_q <= '0;
      stat_cycles_q  <= '0;
    end else begin
      if ((state_q == ROB_IDLE) && bus.flush_req && !(&stat_flushes_q)) begin
        stat_flushes_q <= stat_flushes_q + 16'd1;
      end
      if ((state_q != ROB_IDLE) && !(&stat_cycles_q)) begin
        stat_cycles_q <= stat_cycles_q + 32'd1;
      end
    end
  end

  assign bus.stat_flushes = stat_flushes_q;
  assign bus.stat_cycles  = stat_cycles_q;
`endif

endmodule

// File: tb/tb_rob_recovery_ctrl.sv
// tb/tb_rob_recovery_ctrl.sv - directed self-checking bench for rob_recovery_ctrl
module tb_rob_recovery_ctrl;
  localparam int DEPTH = 16;
  localparam int WIDTH = 2;

  typedef logic [17:0] exp_q_t[$];

  logic clk = 1'b0;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  rob_recovery_ctrl_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  rob_recovery_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Observed vector: state, flush_valid, rb_valid, rb_base, walk_valid,
  // walk_base, recover_done, busy, flush_overrun.
  function automatic logic [17:0] obs();
    return {bus.rob_state, bus.flush_valid, bus.rb_valid, bus.rb_base,
            bus.walk_valid, bus.walk_base, bus.recover_done, bus.busy,
            bus.flush_overrun};
  endfunction

  function automatic logic [17:0] ev(logic [1:0] st, logic fv, logic [1:0] rbv,
                                     logic [3:0] rbb, logic [1:0] wv, logic [3:0] wb,
                                     logic dn, logic ov);
    return {st, fv, rbv, rbb, wv, wb, dn, (st != 2'd0), ov};
  endfunction

  // Expected cycles for head=3, count=10, flush_idx=7, incl=0, followed by
  // one idle cycle. Overrun is expected from cycle ov_from onward.
  function automatic exp_q_t seq_mispredict(int ov_from);
    exp_q_t q;
    q.push_back(ev(2'd1, 1'b1, 2'b11, 4'd12, 2'b00, 4'd0, 1'b0, 0 >= ov_from));
    q.push_back(ev(2'd1, 1'b0, 2'b11, 4'd10, 2'b00, 4'd0, 1'b0, 1 >= ov_from));
    q.push_back(ev(2'd1, 1'b0, 2'b01, 4'd8,  2'b00, 4'd0, 1'b0, 2 >= ov_from));
    q.push_back(ev(2'd2, 1'b0, 2'b00, 4'd0,  2'b11, 4'd3, 1'b0, 3 >= ov_from));
    q.push_back(ev(2'd2, 1'b0, 2'b00, 4'd0,  2'b11, 4'd5, 1'b0, 4 >= ov_from));
    q.push_back(ev(2'd2, 1'b0, 2'b00, 4'd0,  2'b01, 4'd7, 1'b1, 5 >= ov_from));
    q.push_back(ev(2'd0, 1'b0, 2'b00, 4'd0,  2'b00, 4'd0, 1'b0, 6 >= ov_from));
    return q;
  endfunction

  // Expected cycles for head=0, count=4, flush_idx=3, incl=0 (youngest entry),
  // followed by one idle cycle.
  function automatic exp_q_t seq_youngest(int ov_from);
    exp_q_t q;
    q.push_back(ev(2'd1, 1'b1, 2'b00, 4'd3, 2'b00, 4'd0, 1'b0, 0 >= ov_from));
    q.push_back(ev(2'd2, 1'b0, 2'b00, 4'd0, 2'b11, 4'd0, 1'b0, 1 >= ov_from));
    q.push_back(ev(2'd2, 1'b0, 2'b00, 4'd0, 2'b11, 4'd2, 1'b1, 2 >= ov_from));
    q.push_back(ev(2'd0, 1'b0, 2'b00, 4'd0, 2'b00, 4'd0, 1'b0, 3 >= ov_from));
    return q;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(logic [3:0] idx, logic incl, logic [3:0] head, logic [4:0] cnt);
    bus.flush_idx  = idx;
    bus.flush_incl = incl;
    bus.rob_head   = head;
    bus.rob_count  = cnt;
    bus.flush_req  = 1'b1;
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    bus.flush_req = 1'b1;
    bus.flush_idx = 4'd5;
    bus.flush_incl = 1'b0;
    bus.rob_head  = 4'd1;
    bus.rob_count = 5'd8;
    step();
    step();
    checks++;
    if (obs() !== 18'd0) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", obs(), 18'd0);
    end
    bus.flush_req = 1'b0;
    reset_n = 1'b1;
    step();
    checks++;
    if (obs() !== 18'd0) begin
      errors++;
      $display("FAIL reset_release_idle: got %h expected %h", obs(), 18'd0);
    end
  endtask

  task automatic test_mispredict();
    exp_q_t q = seq_mispredict(99);
    issue(4'd7, 1'b0, 4'd3, 5'd10);
    for (int i = 0; i < q.size(); i++) begin
      step();
      bus.flush_req = 1'b0;
      checks++;
      if (obs() !== q[i]) begin
        errors++;
        $display("FAIL mispredict cycle %0d: got %h expected %h", i, obs(), q[i]);
      end
    end
  endtask

  task automatic test_full_wrap();
    exp_q_t q;
    logic [3:0] base = 4'd13;
    for (int i = 0; i < 8; i++) begin
      q.push_back(ev(2'd1, i == 0, 2'b11, base, 2'b00, 4'd0, i == 7, 1'b0));
      base = base - 4'd2;
    end
    q.push_back(ev(2'd0, 1'b0, 2'b00, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0));
    issue(4'd14, 1'b1, 4'd14, 5'd16);
    for (int i = 0; i < q.size(); i++) begin
      step();
      bus.flush_req = 1'b0;
      checks++;
      if (obs() !== q[i]) begin
        errors++;
        $display("FAIL full_wrap cycle %0d: got %h expected %h", i, obs(), q[i]);
      end
    end
  endtask

  task automatic test_youngest();
    exp_q_t q = seq_youngest(99);
    issue(4'd3, 1'b0, 4'd0, 5'd4);
    for (int i = 0; i < q.size(); i++) begin
      step();
      bus.flush_req = 1'b0;
      checks++;
      if (obs() !== q[i]) begin
        errors++;
        $display("FAIL youngest cycle %0d: got %h expected %h", i, obs(), q[i]);
      end
    end
  endtask

  task automatic test_overrun();
    exp_q_t q = seq_mispredict(4);
    issue(4'd7, 1'b0, 4'd3, 5'd10);
    for (int i = 0; i < q.size(); i++) begin
      step();
      bus.flush_req = 1'b0;
      checks++;
      if (obs() !== q[i]) begin
        errors++;
        $display("FAIL overrun cycle %0d: got %h expected %h", i, obs(), q[i]);
      end
      if (i == 3) issue(4'd1, 1'b1, 4'd0, 5'd6);
    end
    step();
    checks++;
    if (bus.flush_overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: got %b expected 1", bus.flush_overrun);
    end
  endtask

  task automatic test_reset_mid();
    exp_q_t q = seq_youngest(99);
    issue(4'd14, 1'b1, 4'd14, 5'd16);
    step();
    bus.flush_req = 1'b0;
    step();
    checks++;
    if (obs() !== ev(2'd1, 1'b0, 2'b11, 4'd11, 2'b00, 4'd0, 1'b0, 1'b1)) begin
      errors++;
      $display("FAIL reset_mid_pre: got %h expected %h", obs(),
               ev(2'd1, 1'b0, 2'b11, 4'd11, 2'b00, 4'd0, 1'b0, 1'b1));
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs() !== 18'd0) begin
      errors++;
      $display("FAIL reset_mid_async: got %h expected %h", obs(), 18'd0);
    end
    step();
    reset_n = 1'b1;
    issue(4'd3, 1'b0, 4'd0, 5'd4);
    for (int i = 0; i < q.size(); i++) begin
      step();
      bus.flush_req = 1'b0;
      checks++;
      if (obs() !== q[i]) begin
        errors++;
        $display("FAIL reset_mid_fresh cycle %0d: got %h expected %h", i, obs(), q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_q_t q1 = seq_youngest(3);
    exp_q_t q2 = seq_mispredict(0);
    issue(4'd3, 1'b0, 4'd0, 5'd4);
    step();
    bus.flush_req = 1'b0;
    for (int i = 0; i < q1.size(); i++) begin
      checks++;
      if (obs() !== q1[i]) begin
        errors++;
        $display("FAIL b2b_first cycle %0d: got %h expected %h", i, obs(), q1[i]);
      end
      // The request is raised in the recover_done cycle and held through the
      // following idle cycle.
      if (i == 2) issue(4'd7, 1'b0, 4'd3, 5'd10);
      if (i < q1.size() - 1) step();
    end
    for (int i = 0; i < q2.size(); i++) begin
      step();
      bus.flush_req = 1'b0;
      checks++;
      if (obs() !== q2[i]) begin
        errors++;
        $display("FAIL b2b_second cycle %0d: got %h expected %h", i, obs(), q2[i]);
      end
    end
  endtask

  initial begin
    bus.flush_req  = 1'b0;
    bus.flush_idx  = '0;
    bus.flush_incl = 1'b0;
    bus.rob_head   = '0;
    bus.rob_count  = '0;
    reset_n        = 1'b0;
    #1;
    test_reset();
    test_mispredict();
    test_full_wrap();
    test_youngest();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
